// File: rtl/latch_write_arbiter_if.sv
// Requester/latch bus of the latch write arbiter: request and data in,
// grant/status and the latch D/En pins out.
interface latch_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    // Handshake: req[i] is a level request. grant is one-hot for the whole
    // transaction, and done marks its last cycle. A requester that wants
    // no further turn drops req (or presents new data) in the cycle after done.
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    grant;
    logic               done;
    logic               busy;
    logic [DW-1:0]      latch_d;
    logic               latch_en;

    modport master (
        output req, wdata,
        input  grant, done, busy, latch_d, latch_en
    );

    modport slave (
        input  req, wdata,
        output grant, done, busy, latch_d, latch_en
    );
endinterface

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that owns one shared level-sensitive latch. It sequences
// D and En as SETUP -> ENABLE -> HOLD so that D is stable around the En window.
module latch_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst,
    latch_write_arbiter_if.slave bus,
    output logic [1:0]          dbg_state_o
);

    localparam int CNT_MAX = (SETUP_CYC > EN_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic          HOLD_ONE = (HOLD_CYC == 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [LW-1:0]    last_q;
    logic [NREQ-1:0]  grant_q;
    logic             done_q;
    logic             busy_q;
    logic             latch_en_q;
    logic [DW-1:0]    latch_d_q;

    logic             pick_vld_d;
    logic [LW-1:0]    pick_idx_d;
    logic [LW-1:0]    cand;
    logic [DW-1:0]    pick_data_d;

    // Search starts one past the previous owner and wraps, so a requester
    // holding req high waits behind every other active requester.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = LW'((int'(last_q) + k) % NREQ);
            if (!pick_vld_d && bus.req[cand]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand;
            end
        end
        pick_data_d = bus.wdata[int'(pick_idx_d)*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= LW'(NREQ - 1);
            grant_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            latch_en_q <= 1'b0;
            latch_d_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_d) begin
                        state_q   <= ST_SETUP;
                        cnt_q     <= SETUP_LD;
                        last_q    <= pick_idx_d;
                        grant_q   <= NREQ'(1) << pick_idx_d;
                        busy_q    <= 1'b1;
                        latch_d_q <= pick_data_d;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q    <= ST_ENABLE;
                        cnt_q      <= EN_LD;
                        latch_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_ENABLE: begin
                    if (cnt_q == '0) begin
                        state_q    <= ST_HOLD;
                        cnt_q      <= HOLD_LD;
                        latch_en_q <= 1'b0;
                        done_q     <= HOLD_ONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_HOLD: begin
                    // latch_d is left untouched so the latch keeps seeing the
                    // written value until the next grant.
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CW'(1);
                        done_q <= (cnt_q == CW'(1));
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.latch_en = latch_en_q;
    assign bus.latch_d  = latch_d_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/latch_write_arbiter.md
Name: latch_write_arbiter

Overview:
- Shares one level-sensitive D latch (data input D, enable En, output Q) between NREQ requesters.
- Grants access round-robin and drives the latch D and En pins through a fixed SETUP -> ENABLE -> HOLD sequence, so D is always stable around the En window.
- Sits between requester logic and the shared latch; the latch itself stays a separate instance.

Parameters:
- NREQ, 4, number of requesters (>=2)
- DW, 8, latch data width
- SETUP_CYC, 1, cycles D is driven before En rises (>=1)
- EN_CYC, 2, cycles En is held high (>=1)
- HOLD_CYC, 1, cycles D is held after En falls (>=1)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req  input  NREQ  per-requester write request, level
- wdata  input  NREQ*DW  requester i data in bits [i*DW +: DW]
- grant  output  NREQ  one-hot, owner of current transaction
- done  output  1  one-cycle pulse, last cycle of transaction
- busy  output  1  high in SETUP/ENABLE/HOLD
- latch_d  output  DW  to latch D
- latch_en  output  1  to latch En

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state=IDLE, grant=0, done=0, busy=0, latch_en=0, latch_d=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, SETUP, ENABLE, HOLD; one down-counter sized for max(SETUP_CYC, EN_CYC, HOLD_CYC).
- IDLE:
  - If any req bit is high, select the first requester with req high, searching from last+1 upward with wrap-around.
  - Next cycle: grant=onehot(sel), latch_d=wdata[sel] (captured once), busy=1, state=SETUP, last=sel.
  - If no req, stay in IDLE; all outputs hold, latch_d keeps its previous value.
- SETUP: SETUP_CYC cycles, latch_en=0, then go to ENABLE.
- ENABLE: EN_CYC cycles, latch_en=1, then go to HOLD.
- HOLD:
  - HOLD_CYC cycles, latch_en=0.
  - done=1 in the final HOLD cycle only.
  - Next cycle: IDLE, grant=0, busy=0, done=0.
- Transaction length: SETUP_CYC+EN_CYC+HOLD_CYC cycles, followed by a mandatory 1-cycle IDLE gap.
  - Requester rule: drop req (or present new data) in the cycle after done.
- latch_d is constant from SETUP through HOLD and afterwards until the next grant. wdata changes after capture are ignored.
- latch_en never glitches, never rises outside ENABLE, and never coincides with a latch_d change.
- Requester drops req mid-transaction: the transaction still completes with the captured data, and done pulses normally.
- Simultaneous requests: round-robin order. A requester that keeps req high continuously gets a turn at most every NREQ transactions while others wait.
- Single active requester: served back-to-back, one transaction per S+E+H+1 cycles.
- rst mid-transaction: next cycle returns to reset values.
  - latch_en drops immediately on that edge and latch_d goes to 0.
  - No done pulse; the pointer resets.
- Invariants: grant is zero or one-hot; busy == (grant != 0).

Test Plan:
- Reset then single request: defaults, req=4'b0001, wdata[0]=8'hA5 at cycle t.
  - grant=0001 and latch_d=A5 from t+1 to t+4; latch_en=1 exactly at t+2 and t+3; done=1 only at t+4; busy=0 at t+5.
- Contention: req=4'b1111 held, wdata[i]=8'h10+i.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - latch_d sequence 10, 11, 12, 13, 10; each transaction 4 cycles plus 1 IDLE gap.
- Data change after capture: wdata[2] changes 8'h3C to 8'hC3 during ENABLE.
  - latch_d stays 3C through HOLD and after done.
- Req withdrawn: req[1] pulsed high for one cycle only.
  - Full 4-cycle transaction still runs; done pulses once; no second grant.
- Reset mid-operation: assert rst during ENABLE.
  - Next cycle latch_en=0, grant=0, busy=0, latch_d=0, no done.
  - Subsequent req=4'b1010 grants 0010 first (pointer reset).
- Invariant checker, random req/wdata for 2000 cycles:
  - grant is always one-hot or zero.
  - latch_d is never changing while latch_en=1.
  - latch_en high-run length is always EN_CYC.
